flag_bank_arbiter: RTL and testbench

FLAG_BANK_ARBITER -- requirements
Module: flag_bank_arbiter

---
 rtl/flag_bank_pkg.sv | 20 ++
 rtl/flag_cell.sv | 25 ++
 rtl/flag_bank_arbiter.sv | 141 ++++++++++++++
 tb/tb_flag_bank_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flag_bank_pkg.sv
// Shared opcode and FSM-state definitions for the flag bank arbiter.
// No logic; types only.
// Imported by flag_bank_arbiter and its bench.
package flag_bank_pkg;

  typedef enum logic [1:0] {
    OP_WRITE  = 2'b00,
    OP_SET    = 2'b01,
    OP_CLEAR  = 2'b10,
    OP_TOGGLE = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GRANT = 2'b01,
    APPLY = 2'b10,
    DONE  = 2'b11
  } state_t;

endpackage

// File: rtl/flag_cell.sv
// One-bit flag register with synchronous reset, clear, set and load enable.
// Latency: q reflects the control inputs one clock after they are sampled.
// No backpressure; priority is reset > clr > set > en, otherwise q holds.
module flag_cell (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic set,
  input  logic en,
  input  logic d,
  output logic q,
  output logic qn
);

  // Prioritised update of the stored bit
  always_ff @(posedge clock) begin
    if (reset)    q <= 1'b0;
    else if (clr) q <= 1'b0;
    else if (set) q <= 1'b1;
    else if (en)  q <= d;
  end

  assign qn = ~q;

endmodule

// File: rtl/flag_bank_arbiter.sv
// Round-robin arbiter granting one requester at a time a write/set/clear/toggle on a flag bank.
// Latency: req in IDLE at N -> gnt at N+1 -> flag visible with done at N+3 -> next grant at N+5.
// Backpressure: requesters hold req and fields until their one-cycle gnt; req is only sampled in IDLE.
module flag_bank_arbiter
  import flag_bank_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int NFLAGS = 8,
  localparam int IW    = (NFLAGS > 1) ? $clog2(NFLAGS) : 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [2*NREQ-1:0]    op,
  input  logic [IW*NREQ-1:0]   idx,
  input  logic [NREQ-1:0]      wdata,
  output logic [NREQ-1:0]      gnt,
  output logic                 done,
  output logic                 busy,
  output logic [NFLAGS-1:0]    flags,
  output logic [NFLAGS-1:0]    flags_n
);

  localparam int RW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t          state, state_nxt;
  logic [RW-1:0]   last_grant;
  logic [RW-1:0]   winner;
  logic [RW-1:0]   rr_pick;
  logic [RW-1:0]   cand;
  logic            rr_found;
  logic [1:0]      sel_op;
  logic [IW-1:0]   sel_idx;
  logic            sel_wdata;
  op_t             lat_op;
  logic [IW-1:0]   lat_idx;
  logic            lat_wdata;

  // Round-robin search: first requester after last_grant, wrapping around
  always_comb begin
    rr_found = 1'b0;
    rr_pick  = last_grant;
    cand     = last_grant;
    for (int k = 1; k <= NREQ; k++) begin
      cand = RW'((int'(last_grant) + k) % NREQ);
      if (!rr_found && req[cand]) begin
        rr_found = 1'b1;
        rr_pick  = cand;
      end
    end
  end

  // Pick out the registered winner's command fields
  always_comb begin
    sel_op    = 2'b00;
    sel_idx   = '0;
    sel_wdata = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (winner == RW'(i)) begin
        sel_op    = op[2*i +: 2];
        sel_idx   = idx[IW*i +: IW];
        sel_wdata = wdata[i];
      end
    end
  end

  // FSM state register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // FSM next state and handshake outputs
  always_comb begin
    state_nxt = state;
    gnt       = '0;
    done      = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (rr_found) state_nxt = GRANT;
      end
      GRANT: begin
        gnt[winner] = 1'b1;
        state_nxt   = APPLY;
      end
      APPLY: state_nxt = DONE;
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Winner / round-robin pointer capture in IDLE, command capture in GRANT
  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant <= RW'(NREQ - 1);
      winner     <= '0;
      lat_op     <= OP_WRITE;
      lat_idx    <= '0;
      lat_wdata  <= 1'b0;
    end else begin
      if (state == IDLE && rr_found) begin
        winner     <= rr_pick;
        last_grant <= rr_pick;
      end
      if (state == GRANT) begin
        lat_op    <= op_t'(sel_op);
        lat_idx   <= sel_idx;
        lat_wdata <= sel_wdata;
      end
    end
  end

  // One cell per flag; an index that matches no cell leaves the bank untouched
  for (genvar i = 0; i < NFLAGS; i++) begin : g_cell
    logic hit;
    logic c_q;
    logic c_qn;

    assign hit = (state == APPLY) && (lat_idx == IW'(i));

    flag_cell u_cell (
      .clock (clock),
      .reset (reset),
      .clr   (hit && (lat_op == OP_CLEAR)),
      .set   (hit && (lat_op == OP_SET)),
      .en    (hit && ((lat_op == OP_WRITE) || (lat_op == OP_TOGGLE))),
      .d     ((lat_op == OP_TOGGLE) ? ~c_q : lat_wdata),
      .q     (c_q),
      .qn    (c_qn)
    );

    assign flags[i]   = c_q;
    assign flags_n[i] = c_qn;
  end

endmodule

// File: tb/tb_flag_bank_arbiter.sv
// Self-checking bench for flag_bank_arbiter: scoreboard of expected grants and post-done flag values.
// A second instance with NFLAGS=6 exercises indices beyond the bank (3-bit index, values 6 and 7).
// Inputs driven just after the falling edge, outputs sampled on the falling edge.
module tb_flag_bank_arbiter;
  import flag_bank_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [7:0]  op;
  logic [11:0] idx;
  logic [3:0]  wdata;
  logic [3:0]  gnt;
  logic        done;
  logic        busy;
  logic [7:0]  flags;
  logic [7:0]  flags_n;

  logic [3:0]  req2;
  logic [7:0]  op2;
  logic [11:0] idx2;
  logic [3:0]  wdata2;
  logic [3:0]  gnt2;
  logic        done2;
  logic        busy2;
  logic [5:0]  flags2;
  logic [5:0]  flags2_n;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  bit mon_en = 1'b0;

  logic [3:0] exp_gnt_q[$];
  logic [7:0] exp_flags_q[$];
  logic [3:0] sb_g;
  logic [7:0] sb_f;

  flag_bank_arbiter #(.NREQ(4), .NFLAGS(8)) dut (
    .clock(clock), .reset(reset), .req(req), .op(op), .idx(idx), .wdata(wdata),
    .gnt(gnt), .done(done), .busy(busy), .flags(flags), .flags_n(flags_n)
  );

  flag_bank_arbiter #(.NREQ(4), .NFLAGS(6)) dut_oor (
    .clock(clock), .reset(reset), .req(req2), .op(op2), .idx(idx2), .wdata(wdata2),
    .gnt(gnt2), .done(done2), .busy(busy2), .flags(flags2), .flags_n(flags2_n)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Scoreboard: every grant and every done is matched against queued expectations
  always @(negedge clock) begin
    if (mon_en) begin
      n_cmp++;
      if (flags_n !== ~flags) begin
        n_err++;
        $display("FAIL flags_n_complement: got %h want %h", flags_n, ~flags);
      end
      if (gnt !== 4'b0000) begin
        n_cmp++;
        if (exp_gnt_q.size() == 0) begin
          n_err++;
          $display("FAIL sb_gnt: got %b want no grant", gnt);
        end else begin
          sb_g = exp_gnt_q.pop_front();
          if (gnt !== sb_g) begin
            n_err++;
            $display("FAIL sb_gnt: got %b want %b", gnt, sb_g);
          end
        end
      end
      if (done !== 1'b0) begin
        n_cmp++;
        if (exp_flags_q.size() == 0) begin
          n_err++;
          $display("FAIL sb_done: got done=%b flags=%h want no done", done, flags);
        end else begin
          sb_f = exp_flags_q.pop_front();
          if (flags !== sb_f) begin
            n_err++;
            $display("FAIL sb_flags: got %h want %h", flags, sb_f);
          end
        end
      end
    end
  end

  task automatic load(input int r, input logic [1:0] o, input int ix, input logic wd);
    op[2*r +: 2]  = o;
    idx[3*r +: 3] = ix[2:0];
    wdata[r]      = wd;
    req[r]        = 1'b1;
  endtask

  // Drives one command and reports grant/done cycles relative to the request cycle (-1 if never seen)
  task automatic run_cmd(input int r, input logic [1:0] o, input int ix, input logic wd,
                         output int gc, output int dc);
    int t0;
    load(r, o, ix, wd);
    t0 = cyc;
    gc = -1;
    dc = -1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      if (gc < 0 && gnt[r] === 1'b1) begin
        gc     = cyc - t0;
        req[r] = 1'b0;
      end
      if (dc < 0 && done === 1'b1) dc = cyc - t0;
      if (dc >= 0) break;
    end
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = '0; op = '0; idx = '0; wdata = '0;
    req2 = '0; op2 = '0; idx2 = '0; wdata2 = '0;
    repeat (3) @(negedge clock);
    n_cmp += 6;
    if (flags !== 8'h00)   begin n_err++; $display("FAIL reset_flags: got %h want 00", flags); end
    if (flags_n !== 8'hFF) begin n_err++; $display("FAIL reset_flags_n: got %h want ff", flags_n); end
    if (gnt !== 4'b0000)   begin n_err++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
    if (done !== 1'b0)     begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
    if (busy !== 1'b0)     begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    if (flags2 !== 6'h00)  begin n_err++; $display("FAIL reset_flags2: got %h want 00", flags2); end
    reset  = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic test_write_latency();
    int gc, dc;
    exp_gnt_q.push_back(4'b0001);
    exp_flags_q.push_back(8'h08);
    run_cmd(0, OP_WRITE, 3, 1'b1, gc, dc);
    n_cmp += 4;
    if (gc !== 1)          begin n_err++; $display("FAIL write_gnt_latency: got %0d want 1", gc); end
    if (dc !== 3)          begin n_err++; $display("FAIL write_done_latency: got %0d want 3", dc); end
    if (flags !== 8'h08)   begin n_err++; $display("FAIL write_flags: got %h want 08", flags); end
    if (busy !== 1'b0)     begin n_err++; $display("FAIL write_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_round_robin();
    int gcyc[4];
    int ng = 0;
    int nd = 0;
    do_reset();
    exp_gnt_q.push_back(4'b0001); exp_flags_q.push_back(8'h01);
    exp_gnt_q.push_back(4'b0010); exp_flags_q.push_back(8'h03);
    exp_gnt_q.push_back(4'b0100); exp_flags_q.push_back(8'h07);
    exp_gnt_q.push_back(4'b1000); exp_flags_q.push_back(8'h0F);
    for (int r = 0; r < 4; r++) load(r, OP_SET, r, 1'b0);
    for (int k = 0; k < 40 && nd < 4; k++) begin
      @(negedge clock);
      if (gnt !== 4'b0000 && ng < 4) begin
        gcyc[ng] = cyc;
        ng++;
        if (ng == 4) req = '0;
      end
      if (done === 1'b1) nd++;
    end
    @(negedge clock);
    n_cmp += 2;
    if (ng !== 4)        begin n_err++; $display("FAIL rr_grant_count: got %0d want 4", ng); end
    if (flags !== 8'h0F) begin n_err++; $display("FAIL rr_flags: got %h want 0f", flags); end
    for (int j = 1; j < ng; j++) begin
      n_cmp++;
      if (gcyc[j] - gcyc[j-1] !== 4) begin
        n_err++;
        $display("FAIL rr_spacing_%0d: got %0d want 4", j, gcyc[j] - gcyc[j-1]);
      end
    end
  endtask

  task automatic test_toggle_clear();
    int         r_t[2] = '{2, 3};
    logic [1:0] o_t[2] = '{OP_TOGGLE, OP_CLEAR};
    int         i_t[2] = '{0, 1};
    logic [7:0] f_t[2] = '{8'h0E, 8'h0C};
    logic [3:0] g;
    int gc, dc;
    for (int t = 0; t < 2; t++) begin
      g = 4'b0001 << r_t[t];
      exp_gnt_q.push_back(g);
      exp_flags_q.push_back(f_t[t]);
      run_cmd(r_t[t], o_t[t], i_t[t], 1'b0, gc, dc);
      n_cmp++;
      if (flags !== f_t[t]) begin n_err++; $display("FAIL tc_flags_%0d: got %h want %h", t, flags, f_t[t]); end
    end
    n_cmp++;
    if (flags_n !== 8'hF3) begin n_err++; $display("FAIL tc_flags_n: got %h want f3", flags_n); end
  endtask

  task automatic test_reset_abort();
    exp_gnt_q.push_back(4'b0001);
    load(0, OP_SET, 5, 1'b0);
    @(negedge clock);
    n_cmp++;
    if (gnt !== 4'b0001) begin n_err++; $display("FAIL abort_gnt: got %b want 0001", gnt); end
    req[0] = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    n_cmp += 4;
    if (done !== 1'b0)     begin n_err++; $display("FAIL abort_done: got %b want 0", done); end
    if (flags !== 8'h00)   begin n_err++; $display("FAIL abort_flags: got %h want 00", flags); end
    if (flags_n !== 8'hFF) begin n_err++; $display("FAIL abort_flags_n: got %h want ff", flags_n); end
    if (busy !== 1'b0)     begin n_err++; $display("FAIL abort_busy: got %b want 0", busy); end
    reset = 1'b0;
    repeat (4) @(negedge clock);
    n_cmp++;
    if (flags !== 8'h00)   begin n_err++; $display("FAIL abort_flags_later: got %h want 00", flags); end
  endtask

  task automatic test_busy_pulse();
    bit saw2 = 1'b0;
    exp_gnt_q.push_back(4'b0010);
    exp_flags_q.push_back(8'h40);
    load(1, OP_WRITE, 6, 1'b1);
    @(negedge clock);
    req[1] = 1'b0;
    load(2, OP_CLEAR, 6, 1'b0);
    @(negedge clock);
    req[2] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if (gnt[2] === 1'b1) saw2 = 1'b1;
    end
    n_cmp += 2;
    if (saw2 !== 1'b0)   begin n_err++; $display("FAIL pulse_gnt2: got %b want 0", saw2); end
    if (flags !== 8'h40) begin n_err++; $display("FAIL pulse_flags: got %h want 40", flags); end
  endtask

  task automatic test_back_to_back();
    int g0 = -1;
    int g3 = -1;
    int t0;
    exp_gnt_q.push_back(4'b1000); exp_flags_q.push_back(8'hC0);
    exp_gnt_q.push_back(4'b0001); exp_flags_q.push_back(8'h80);
    load(0, OP_CLEAR, 6, 1'b0);
    load(3, OP_SET, 7, 1'b0);
    t0 = cyc;
    for (int k = 0; k < 20 && g0 < 0; k++) begin
      @(negedge clock);
      if (gnt[3] === 1'b1 && g3 < 0) begin g3 = cyc - t0; req[3] = 1'b0; end
      if (gnt[0] === 1'b1 && g0 < 0) begin g0 = cyc - t0; req[0] = 1'b0; end
    end
    repeat (4) @(negedge clock);
    n_cmp += 3;
    if (g3 !== 1)        begin n_err++; $display("FAIL b2b_first_gnt: got %0d want 1", g3); end
    if (g0 !== 5)        begin n_err++; $display("FAIL b2b_second_gnt: got %0d want 5", g0); end
    if (flags !== 8'h80) begin n_err++; $display("FAIL b2b_flags: got %h want 80", flags); end
  endtask

  task automatic test_out_of_range();
    logic [1:0] o_t[3] = '{OP_SET, OP_WRITE, OP_TOGGLE};
    int         i_t[3] = '{2, 7, 6};
    int v, t0, g, d;
    for (int t = 0; t < 3; t++) begin
      v          = i_t[t];
      op2[1:0]   = o_t[t];
      idx2[2:0]  = v[2:0];
      wdata2[0]  = 1'b1;
      req2[0]    = 1'b1;
      t0 = cyc; g = -1; d = -1;
      for (int k = 0; k < 12 && d < 0; k++) begin
        @(negedge clock);
        if (g < 0 && gnt2 === 4'b0001) begin g = cyc - t0; req2[0] = 1'b0; end
        if (d < 0 && done2 === 1'b1) d = cyc - t0;
      end
      @(negedge clock);
      n_cmp += 3;
      if (g !== 1)          begin n_err++; $display("FAIL oor_gnt_%0d: got %0d want 1", t, g); end
      if (d !== 3)          begin n_err++; $display("FAIL oor_done_%0d: got %0d want 3", t, d); end
      if (flags2 !== 6'h04) begin n_err++; $display("FAIL oor_flags_%0d: got %h want 04", t, flags2); end
    end
  endtask

  initial begin
    test_reset();
    test_write_latency();
    test_round_robin();
    test_toggle_clear();
    test_reset_abort();
    test_busy_pulse();
    test_back_to_back();
    test_out_of_range();
    n_cmp++;
    if (exp_gnt_q.size() != 0 || exp_flags_q.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain: got %0d grants and %0d dones outstanding want 0 and 0",
               exp_gnt_q.size(), exp_flags_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
